// File: rtl/ram_io_responder.sv
// Bus target for the byte-serial memory controller: byte-addressed RAM plus an I/O
// window holding a TX FIFO toward the UART, an RX byte latch and a halt register.
module ram_io_responder #(
  parameter int          ADDR_WIDTH  = 17,
  parameter logic [31:0] IO_BASE     = 32'h30000,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        ram_type,
  input  logic [31:0] addr_ram,
  input  logic [7:0]  data_ram,
  output logic [7:0]  data_ram_in,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        prog_done,
  output logic        tx_overflow
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [31:0]      HALT_ADDR  = IO_BASE + 32'd4;
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_DEPTH - FULL_MARGIN);

  logic [7:0] ram_mem  [RAM_DEPTH];
  logic [7:0] fifo_mem [FIFO_DEPTH];

  logic [7:0]       data_ram_in_q, data_ram_in_d;
  logic             io_buffer_full_q, io_buffer_full_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rx_full_q, rx_full_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             prog_done_q, prog_done_d;
  logic             tx_overflow_q, tx_overflow_d;

  logic is_ram, is_uart, is_halt;
  logic bus_wr, bus_rd;
  logic fifo_full, fifo_empty;
  logic push, pop, ram_we, rx_pop;

  always_comb begin
    is_ram     = ((addr_ram >> ADDR_WIDTH) == 32'd0);
    is_uart    = (addr_ram == IO_BASE);
    is_halt    = (addr_ram == HALT_ADDR);
    bus_wr     = rdy_in & ram_type;
    bus_rd     = rdy_in & ~ram_type;
    fifo_full  = (count_q == DEPTH_CNT);
    fifo_empty = (count_q == '0);
    ram_we     = bus_wr & is_ram;
    // A full FIFO rejects the push even when the UART drains an entry this cycle.
    push       = bus_wr & is_uart & ~is_ram & ~fifo_full;
    pop        = ~fifo_empty & tx_ready;
    rx_pop     = bus_rd & is_uart & ~is_ram;
  end

  always_comb begin
    data_ram_in_d    = data_ram_in_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    rx_full_d        = rx_full_q;
    rx_byte_d        = rx_byte_q;
    prog_done_d      = prog_done_q;
    tx_overflow_d    = tx_overflow_q;

    if (bus_rd) begin
      if (is_ram)       data_ram_in_d = ram_mem[addr_ram[ADDR_WIDTH-1:0]];
      else if (is_uart) data_ram_in_d = rx_full_q ? rx_byte_q : 8'h00;
      else if (is_halt) data_ram_in_d = {6'b0, rx_full_q, fifo_empty};
      else              data_ram_in_d = 8'h00;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    io_buffer_full_d = (count_d >= FULL_LEVEL);

    if (bus_wr && is_uart && !is_ram && fifo_full) tx_overflow_d = 1'b1;
    if (bus_wr && is_halt && !is_ram)              prog_done_d   = 1'b1;

    // A byte arriving in the same cycle as a read pop wins and keeps the latch full.
    if (rx_pop) rx_full_d = 1'b0;
    if (rx_valid) begin
      rx_full_d = 1'b1;
      rx_byte_d = rx_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_ram_in_q    <= 8'h00;
      io_buffer_full_q <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      rx_full_q        <= 1'b0;
      prog_done_q      <= 1'b0;
      tx_overflow_q    <= 1'b0;
    end else begin
      data_ram_in_q    <= data_ram_in_d;
      io_buffer_full_q <= io_buffer_full_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      rx_full_q        <= rx_full_d;
      prog_done_q      <= prog_done_d;
      tx_overflow_q    <= tx_overflow_d;
    end
  end

  // Storage is never cleared; writes are suppressed while reset is held.
  always_ff @(posedge clk_in) begin
    if (ram_we && rst_n_in) ram_mem[addr_ram[ADDR_WIDTH-1:0]] <= data_ram;
    if (push && rst_n_in)   fifo_mem[wr_ptr_q] <= data_ram;
    rx_byte_q <= rx_byte_d;
  end

  assign data_ram_in    = data_ram_in_q;
  assign io_buffer_full = io_buffer_full_q;
  assign tx_valid       = ~fifo_empty;
  assign tx_data        = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign prog_done      = prog_done_q;
  assign tx_overflow    = tx_overflow_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed and randomized bench for ram_io_responder, checked against a queue/array
// reference model of the bus target.
module tb_ram_io_responder;

  localparam logic [31:0] IO_BASE   = 32'h30000;
  localparam logic [31:0] HALT_ADDR = 32'h30004;
  localparam logic [31:0] RAM_BYTES = 32'h20000;
  localparam int          DEPTH     = 8;
  localparam int          MARGIN    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        ram_type;
  logic [31:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  data_ram_in;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        prog_done;
  logic        tx_overflow;

  always #5 clk = ~clk;

  ram_io_responder dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .ram_type(ram_type),
    .addr_ram(addr), .data_ram(wdata), .data_ram_in(data_ram_in),
    .io_buffer_full(io_buffer_full), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .prog_done(prog_done), .tx_overflow(tx_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] fq [$];
  logic       rx_full_m;
  logic [7:0] rx_byte_m;
  logic       prog_m, ovf_m;
  logic [7:0] exp_rd;
  logic       rd_known;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    rx_full_m = 1'b0;
    rx_byte_m = 8'h00;
    prog_m    = 1'b0;
    ovf_m     = 1'b0;
    exp_rd    = 8'h00;
    rd_known  = 1'b1;
  endtask

  task automatic model_edge();
    bit was_full  = (fq.size() == DEPTH);
    bit was_empty = (fq.size() == 0);
    bit do_push   = 1'b0;
    if (rdy) begin
      if (ram_type) begin
        rd_known = 1'b0;
        if (addr < RAM_BYTES)       ram_m[int'(addr)] = wdata;
        else if (addr == IO_BASE)   begin if (was_full) ovf_m = 1'b1; else do_push = 1'b1; end
        else if (addr == HALT_ADDR) prog_m = 1'b1;
      end else begin
        rd_known = 1'b1;
        if (addr < RAM_BYTES) begin
          if (ram_m.exists(int'(addr))) exp_rd = ram_m[int'(addr)];
          else rd_known = 1'b0;
        end else if (addr == IO_BASE) begin
          exp_rd    = rx_full_m ? rx_byte_m : 8'h00;
          rx_full_m = 1'b0;
        end else if (addr == HALT_ADDR) begin
          exp_rd = {6'b0, rx_full_m, was_empty};
        end else begin
          exp_rd = 8'h00;
        end
      end
    end
    if (!was_empty && tx_ready) void'(fq.pop_front());
    if (do_push) fq.push_back(wdata);
    if (rx_valid) begin
      rx_full_m = 1'b1;
      rx_byte_m = rx_data;
    end
  endtask

  task automatic check_all();
    if (rd_known) chk("data_ram_in", data_ram_in, exp_rd);
    chk("io_buffer_full", 8'(io_buffer_full), 8'(fq.size() >= DEPTH - MARGIN));
    chk("tx_valid", 8'(tx_valid), 8'(fq.size() != 0));
    chk("tx_data", tx_data, (fq.size() != 0) ? fq[0] : 8'h00);
    chk("prog_done", 8'(prog_done), 8'(prog_m));
    chk("tx_overflow", 8'(tx_overflow), 8'(ovf_m));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    rx_valid = 1'b0;
  endtask

  task automatic bus(input logic r, input logic t, input logic [31:0] a, input logic [7:0] d);
    rdy      = r;
    ram_type = t;
    addr     = a;
    wdata    = d;
    step();
  endtask

  logic [31:0] pool [5];

  initial begin
    pool[0] = 32'h100; pool[1] = 32'h101; pool[2] = 32'h102;
    pool[3] = 32'h103; pool[4] = 32'h200;
    rst_n = 1'b0; rdy = 1'b0; ram_type = 1'b0; addr = '0; wdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    model_reset();

    // Reset state
    #12;
    chk("rst_data_ram_in", data_ram_in, 8'h00);
    chk("rst_io_buffer_full", 8'(io_buffer_full), 8'h00);
    chk("rst_tx_valid", 8'(tx_valid), 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_prog_done", 8'(prog_done), 8'h00);
    chk("rst_tx_overflow", 8'(tx_overflow), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // RAM write then back-to-back reads
    bus(1, 1, 32'h100, 8'h11);
    bus(1, 1, 32'h101, 8'h22);
    bus(1, 1, 32'h102, 8'h33);
    bus(1, 1, 32'h103, 8'h44);
    bus(1, 1, 32'h200, 8'hA5);
    bus(1, 0, 32'h100, 8'h00); chk("t1_rd100", data_ram_in, 8'h11);
    bus(1, 0, 32'h101, 8'h00); chk("t1_rd101", data_ram_in, 8'h22);
    bus(1, 0, 32'h102, 8'h00); chk("t1_rd102", data_ram_in, 8'h33);
    bus(1, 0, 32'h103, 8'h00); chk("t1_rd103", data_ram_in, 8'h44);
    bus(1, 1, 32'h104, 8'h66);
    bus(1, 0, 32'h104, 8'h00); chk("t1_wr_then_rd", data_ram_in, 8'h66);
    bus(1, 0, 32'h40000, 8'h00); chk("t1_unmapped_rd", data_ram_in, 8'h00);

    // rdy low freezes writes and halt; data_ram_in holds
    bus(1, 0, 32'h101, 8'h00);
    bus(0, 1, 32'h200, 8'h5C); chk("t5_hold_data", data_ram_in, 8'h22);
    bus(0, 1, HALT_ADDR, 8'h01); chk("t5_prog_frozen", 8'(prog_done), 8'h00);
    bus(1, 1, HALT_ADDR, 8'h01); chk("t5_prog_set", 8'(prog_done), 8'h01);
    bus(1, 0, 32'h200, 8'h00); chk("t5_ram_unchanged", data_ram_in, 8'hA5);

    // RX latch
    rx_data = 8'h5A; rx_valid = 1'b1;
    bus(0, 0, 32'h0, 8'h00);
    bus(1, 0, HALT_ADDR, 8'h00); chk("t4_status_full", data_ram_in, 8'h03);
    bus(1, 0, IO_BASE, 8'h00);   chk("t4_rx_byte", data_ram_in, 8'h5A);
    bus(1, 0, IO_BASE, 8'h00);   chk("t4_rx_empty", data_ram_in, 8'h00);
    bus(1, 0, HALT_ADDR, 8'h00); chk("t4_status_bit1", 8'(data_ram_in[1]), 8'h00);

    // Fill TX FIFO with UART stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus(1, 1, IO_BASE, 8'h80 + 8'(i));
      if (i == 4) chk("t2_not_full_5", 8'(io_buffer_full), 8'h00);
    end
    chk("t2_full_6", 8'(io_buffer_full), 8'h01);
    bus(1, 1, IO_BASE, 8'h86);
    bus(1, 1, IO_BASE, 8'h87); chk("t2_no_ovf_8", 8'(tx_overflow), 8'h00);
    bus(1, 1, IO_BASE, 8'h88); chk("t2_ovf_9", 8'(tx_overflow), 8'h01);

    // Full FIFO drained while writes continue, across pointer wrap
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) bus(1, 1, IO_BASE, 8'hC0 + 8'(i));
    for (int i = 0; i < DEPTH + 2; i++) bus(1, 0, 32'h40000, 8'h00);
    chk("t3_drained", 8'(tx_valid), 8'h00);

    // Async reset mid-stream with 3 bytes queued
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus(1, 1, IO_BASE, 8'hE0 + 8'(i));
    bus(1, 0, 32'h100, 8'h00); chk("t6_pre_rd", data_ram_in, 8'h11);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_tx_valid", 8'(tx_valid), 8'h00);
    chk("t6_io_buffer_full", 8'(io_buffer_full), 8'h00);
    chk("t6_data_ram_in", data_ram_in, 8'h00);
    chk("t6_tx_overflow", 8'(tx_overflow), 8'h00);
    chk("t6_prog_done", 8'(prog_done), 8'h00);
    model_reset();
    rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus(1, 0, 32'h103, 8'h00); chk("t6_ram_kept", data_ram_in, 8'h44);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0, 1, 5: a = pool[$urandom_range(0, 4)];
        2:       a = IO_BASE;
        3:       a = HALT_ADDR;
        default: a = ($urandom_range(0, 1) != 0) ? 32'h40000 : 32'h30001;
      endcase
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = ($urandom_range(0, 4) == 0);
      rx_data  = 8'($urandom);
      bus(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
